tick_serializer: RTL and testbench

- Tick-paced parallel-to-serial frame transmitter (UART-style framing).
- Sits directly downstream of the divide-by-3 strobe generator: that block's one-cycle strobe drives `tick`, and each serial bit lasts exactly one tick interval.
- Accepts a parallel word over a valid/ready handshake and emits: start bit, DATA_W data bits LSB first, optional parity, then stop bit(s).

---
 rtl/tick_serializer_pkg.sv | 32 +++
 rtl/tick_serializer.sv | 147 ++++++++++++++
 tb/tb_tick_serializer.sv | 361 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tick_serializer_pkg.sv
// Shared types and helpers for the tick-paced serial frame transmitter.
// Provides the FSM state encoding, the frame-length helper and the parity function.
package tick_serializer_pkg;

  localparam int unsigned STATE_W    = 3;
  localparam int unsigned MAX_DATA_W = 16;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_ARM    = 3'd1,
    ST_START  = 3'd2,
    ST_DATA   = 3'd3,
    ST_PARITY = 3'd4,
    ST_STOP   = 3'd5
  } state_t;

  // Frame length in tick intervals: start + data + optional parity + stop bits.
  function automatic int unsigned frame_len(input int unsigned data_w,
                                            input int unsigned parity_en,
                                            input int unsigned stop_bits);
    return 1 + data_w + parity_en + stop_bits;
  endfunction

  // Frame length for the default configuration (8 data, parity, 1 stop).
  localparam int unsigned FRAME_LEN_DEFAULT = frame_len(8, 1, 1);

  // Parity over a zero-extended word; odd=1 inverts to give odd parity.
  function automatic logic par(input logic [MAX_DATA_W-1:0] word, input logic odd);
    return (^word) ^ odd;
  endfunction

endpackage

// File: rtl/tick_serializer.sv
// Tick-paced parallel-to-serial frame transmitter with UART-style framing.
// Ports:
//   clk      - system clock, rising edge
//   reset    - asynchronous active-low reset
//   tick     - one-cycle bit-rate strobe; each serial bit lasts one tick interval
//   in_data  - word to transmit (DATA_W bits)
//   in_valid - in_data valid
//   in_ready - block can accept a word (combinational from state)
//   tx       - registered serial line, idles high
//   busy     - frame in progress (combinational from state)
//   done     - registered one-cycle pulse when the final stop bit ends
module tick_serializer
  import tick_serializer_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned PARITY_EN  = 1,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  state_t              state_q, state_d;
  logic                tx_q, tx_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                par_q, par_d;

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
      shift_q <= '0;
      cnt_q   <= '0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
    end
  end

  // Next-state and next-output logic. tx is loaded on the tick edge that enters
  // a bit, so each state's dwell time is exactly the bit it drives on the line.
  // cnt_q counts data bits in START/DATA and is reused as the stop-bit counter.
  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    par_d   = par_q;

    unique case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (in_valid) begin
          shift_d = in_data;
          cnt_d   = '0;
          par_d   = par(MAX_DATA_W'(in_data), 1'(PARITY_ODD));
          state_d = ST_ARM;
        end
      end

      // Align the start bit to a tick so it lasts a full interval.
      ST_ARM: begin
        if (tick) begin
          tx_d    = 1'b0;
          state_d = ST_START;
        end
      end

      ST_START: begin
        if (tick) begin
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = ST_DATA;
        end
      end

      ST_DATA: begin
        if (tick) begin
          if (cnt_q == CNT_W'(DATA_W)) begin
            cnt_d = '0;
            if (PARITY_EN != 0) begin
              tx_d    = par_q;
              state_d = ST_PARITY;
            end else begin
              tx_d    = 1'b1;
              state_d = ST_STOP;
            end
          end else begin
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
      end

      ST_PARITY: begin
        if (tick) begin
          tx_d    = 1'b1;
          state_d = ST_STOP;
        end
      end

      ST_STOP: begin
        if (tick) begin
          if (cnt_q == CNT_W'(STOP_BITS - 1)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  assign in_ready = (state_q == ST_IDLE);
  assign busy     = (state_q != ST_IDLE);
  assign tx       = tx_q;
  assign done     = done_q;

endmodule

// File: tb/tb_tick_serializer.sv
// Directed bench for tick_serializer: three configurations share one stimulus
// stream (default even parity, odd parity, no parity with two stop bits), all
// of which produce 11-interval frames so they stay in lock-step.
module tb_tick_serializer;
  import tick_serializer_pkg::*;

  localparam int FL      = int'(FRAME_LEN_DEFAULT);
  localparam int TIMEOUT = 60;

  logic       clk;
  logic       reset;
  logic       tick;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready0, in_ready1, in_ready2;
  logic       tx0, tx1, tx2;
  logic       busy0, busy1, busy2;
  logic       done0, done1, done2;

  int n_checks;
  int n_fail;
  int tick_mode;   // 0: off, 1: divide-by-3 strobe, 2: stuck high
  int div_cnt;
  int done_pulses;

  tick_serializer #(.DATA_W(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_dut0 (
    .clk(clk), .reset(reset), .tick(tick), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready0), .tx(tx0), .busy(busy0), .done(done0));

  tick_serializer #(.DATA_W(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_dut1 (
    .clk(clk), .reset(reset), .tick(tick), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready1), .tx(tx1), .busy(busy1), .done(done1));

  tick_serializer #(.DATA_W(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_dut2 (
    .clk(clk), .reset(reset), .tick(tick), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready2), .tx(tx2), .busy(busy2), .done(done2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the divide-by-3 strobe stage, updated away from the rising edge.
  always @(negedge clk) begin
    if (tick_mode == 1) begin
      div_cnt = (div_cnt == 2) ? 0 : div_cnt + 1;
      tick    = (div_cnt == 2);
    end else begin
      tick = (tick_mode == 2);
    end
  end

  always @(posedge clk) if (done0 === 1'b1) done_pulses++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present a word and hold it until the accepting edge.
  task automatic send_word(input logic [7:0] w, output bit ok);
    int n;
    n        = 0;
    in_data  = w;
    in_valid = 1'b1;
    while (in_ready0 !== 1'b1 && n < TIMEOUT) begin
      step(1);
      n++;
    end
    step(1);
    in_valid = 1'b0;
    ok = (n < TIMEOUT);
  endtask

  // Wait for the start bit, then sample every bit mid-interval on all DUTs.
  task automatic capture_frame(input int p, input int nbits,
                               output logic [10:0] f0, output logic [10:0] f1,
                               output logic [10:0] f2, output int wait_cyc,
                               output int busy_len, output int done_at,
                               output int done_n, output int rebusy_at);
    bit idle_seen;
    f0 = '1; f1 = '1; f2 = '1;
    wait_cyc = 0;
    while (tx0 !== 1'b0 && wait_cyc < TIMEOUT) begin
      step(1);
      wait_cyc++;
    end
    busy_len = 0; done_at = -1; done_n = 0; rebusy_at = -1; idle_seen = 0;
    for (int c = 0; c < nbits * p + 2; c++) begin
      if ((c % p) == (p / 2) && (c / p) < nbits) begin
        f0[c / p] = tx0;
        f1[c / p] = tx1;
        f2[c / p] = tx2;
      end
      if (done0 === 1'b1) begin
        done_n++;
        if (done_at < 0) done_at = c;
      end
      if (busy0 !== 1'b1) idle_seen = 1;
      else if (!idle_seen) busy_len++;
      else if (rebusy_at < 0) rebusy_at = c;
      step(1);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step(3);
    n_checks++;
    if (tx0 !== 1'b1 || in_ready0 !== 1'b1 || busy0 !== 1'b0 || done0 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold: got tx=%b rdy=%b busy=%b done=%b required 1 1 0 0",
               tx0, in_ready0, busy0, done0);
    end
    reset = 1'b1;
    step(1);
    n_checks++;
    if (tx0 !== 1'b1 || in_ready0 !== 1'b1 || busy0 !== 1'b0 || done0 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got tx=%b rdy=%b busy=%b done=%b required 1 1 0 0",
               tx0, in_ready0, busy0, done0);
    end
    tick_mode = 1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      n_checks++;
      if (tx0 !== 1'b1 || tx2 !== 1'b1 || in_ready0 !== 1'b1 || busy0 !== 1'b0 ||
          done0 !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_tick cycle %0d: got tx=%b rdy=%b busy=%b done=%b required 1 1 0 0",
                 i, tx0, in_ready0, busy0, done0);
      end
    end
  endtask

  task automatic test_default_frame();
    logic [10:0] f0, f1, f2;
    int w, bl, da, dn, rb;
    bit ok;
    tick_mode = 1;
    send_word(8'hA5, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL a5_accept: got timeout required accept"); end
    capture_frame(3, FL, f0, f1, f2, w, bl, da, dn, rb);
    n_checks++;
    if (w < 1 || w > 3) begin n_fail++; $display("FAIL a5_arm_wait: got %0d required 1..3", w); end
    n_checks++;
    if (f0 !== {1'b1, 1'b0, 8'hA5, 1'b0}) begin
      n_fail++; $display("FAIL a5_even: got %b required %b", f0, {1'b1, 1'b0, 8'hA5, 1'b0});
    end
    n_checks++;
    if (f1 !== {1'b1, 1'b1, 8'hA5, 1'b0}) begin
      n_fail++; $display("FAIL a5_odd: got %b required %b", f1, {1'b1, 1'b1, 8'hA5, 1'b0});
    end
    n_checks++;
    if (f2 !== {1'b1, 1'b1, 8'hA5, 1'b0}) begin
      n_fail++; $display("FAIL a5_nopar_2stop: got %b required %b", f2, {1'b1, 1'b1, 8'hA5, 1'b0});
    end
    n_checks++;
    if (bl != 33) begin n_fail++; $display("FAIL a5_busy_len: got %0d required 33", bl); end
    n_checks++;
    if (dn != 1 || da != 33) begin
      n_fail++; $display("FAIL a5_done: got %0d pulses at %0d required 1 at 33", dn, da);
    end
  endtask

  task automatic test_parity_variants();
    logic [10:0] f0, f1, f2;
    int w, bl, da, dn, rb;
    bit ok;
    send_word(8'h07, ok);
    capture_frame(3, FL, f0, f1, f2, w, bl, da, dn, rb);
    n_checks++;
    if (f0 !== {1'b1, 1'b1, 8'h07, 1'b0}) begin
      n_fail++; $display("FAIL 07_even: got %b required %b", f0, {1'b1, 1'b1, 8'h07, 1'b0});
    end
    n_checks++;
    if (f1 !== {1'b1, 1'b0, 8'h07, 1'b0}) begin
      n_fail++; $display("FAIL 07_odd: got %b required %b", f1, {1'b1, 1'b0, 8'h07, 1'b0});
    end
    send_word(8'h00, ok);
    capture_frame(3, FL, f0, f1, f2, w, bl, da, dn, rb);
    n_checks++;
    if (f2 !== {1'b1, 1'b1, 8'h00, 1'b0}) begin
      n_fail++; $display("FAIL 00_nopar_2stop: got %b required %b", f2, {1'b1, 1'b1, 8'h00, 1'b0});
    end
    n_checks++;
    if (f0 !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
      n_fail++; $display("FAIL 00_even: got %b required %b", f0, {1'b1, 1'b0, 8'h00, 1'b0});
    end
    n_checks++;
    if (dn != 1) begin n_fail++; $display("FAIL 00_done_count: got %0d required 1", dn); end
  endtask

  task automatic test_back_to_back();
    logic [10:0] f0, f1, f2;
    int w, bl, da, dn, rb, n;
    in_data  = 8'h3C;
    in_valid = 1'b1;
    n = 0;
    while (in_ready0 !== 1'b0 && n < TIMEOUT) begin step(1); n++; end
    in_data = 8'hC3;
    capture_frame(3, FL, f0, f1, f2, w, bl, da, dn, rb);
    in_valid = 1'b0;
    n_checks++;
    if (f0 !== {1'b1, 1'b0, 8'h3C, 1'b0}) begin
      n_fail++; $display("FAIL b2b_first: got %b required %b", f0, {1'b1, 1'b0, 8'h3C, 1'b0});
    end
    n_checks++;
    if (rb != 34) begin
      n_fail++; $display("FAIL b2b_accept_cycle: got %0d required 34", rb);
    end
    capture_frame(3, FL, f0, f1, f2, w, bl, da, dn, rb);
    n_checks++;
    if (w < 1 || w >= TIMEOUT) begin
      n_fail++; $display("FAIL b2b_idle_gap: got %0d required >=1", w);
    end
    n_checks++;
    if (f0 !== {1'b1, 1'b0, 8'hC3, 1'b0}) begin
      n_fail++; $display("FAIL b2b_second: got %b required %b", f0, {1'b1, 1'b0, 8'hC3, 1'b0});
    end
    n_checks++;
    if (f2 !== {1'b1, 1'b1, 8'hC3, 1'b0}) begin
      n_fail++; $display("FAIL b2b_second_2stop: got %b required %b", f2, {1'b1, 1'b1, 8'hC3, 1'b0});
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [10:0] f0, f1, f2;
    int w, bl, da, dn, rb;
    bit ok;
    send_word(8'h00, ok);
    w = 0;
    while (tx0 !== 1'b0 && w < TIMEOUT) begin step(1); w++; end
    step(16);
    n_checks++;
    if (tx0 !== 1'b0 || busy0 !== 1'b1) begin
      n_fail++; $display("FAIL midframe_pre: got tx=%b busy=%b required 0 1", tx0, busy0);
    end
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if (tx0 !== 1'b1 || busy0 !== 1'b0 || in_ready0 !== 1'b1 || done0 !== 1'b0) begin
      n_fail++;
      $display("FAIL midframe_async_reset: got tx=%b busy=%b rdy=%b done=%b required 1 0 1 0",
               tx0, busy0, in_ready0, done0);
    end
    step(2);
    reset = 1'b1;
    step(2);
    send_word(8'h5A, ok);
    capture_frame(3, FL, f0, f1, f2, w, bl, da, dn, rb);
    n_checks++;
    if (f0 !== {1'b1, 1'b0, 8'h5A, 1'b0}) begin
      n_fail++; $display("FAIL post_reset_5a: got %b required %b", f0, {1'b1, 1'b0, 8'h5A, 1'b0});
    end
    n_checks++;
    if (f2 !== {1'b1, 1'b1, 8'h5A, 1'b0}) begin
      n_fail++; $display("FAIL post_reset_5a_2stop: got %b required %b", f2, {1'b1, 1'b1, 8'h5A, 1'b0});
    end
    n_checks++;
    if (dn != 1) begin n_fail++; $display("FAIL post_reset_done: got %0d required 1", dn); end
  endtask

  task automatic test_tick_gap();
    logic [10:0] fb;
    int w, hold_bad, d0;
    bit ok;
    fb = '1;
    send_word(8'h96, ok);
    w = 0;
    while (tx0 !== 1'b0 && w < TIMEOUT) begin step(1); w++; end
    n_checks++;
    if (w >= TIMEOUT) begin n_fail++; $display("FAIL gap_start: got timeout required start bit"); end
    d0 = done_pulses;
    for (int c = 0; c < 13; c++) begin
      if ((c % 3) == 1) fb[c / 3] = tx0;
      step(1);
    end
    fb[4] = tx0;
    tick_mode = 0;
    hold_bad = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (tx0 !== 1'b0 || busy0 !== 1'b1) hold_bad++;
    end
    n_checks++;
    if (hold_bad != 0) begin
      n_fail++; $display("FAIL gap_hold: got %0d moving cycles required 0", hold_bad);
    end
    div_cnt   = 0;
    tick_mode = 1;
    step(3);
    for (int k = 5; k < 11; k++) begin
      fb[k] = tx0;
      step(3);
    end
    step(2);
    n_checks++;
    if (fb !== {1'b1, 1'b0, 8'h96, 1'b0}) begin
      n_fail++; $display("FAIL gap_frame: got %b required %b", fb, {1'b1, 1'b0, 8'h96, 1'b0});
    end
    n_checks++;
    if (done_pulses - d0 != 1) begin
      n_fail++; $display("FAIL gap_done: got %0d required 1", done_pulses - d0);
    end
  endtask

  task automatic test_tick_stuck_high();
    logic [10:0] f0, f1, f2;
    int w, bl, da, dn, rb;
    bit ok;
    tick_mode = 2;
    step(2);
    send_word(8'h81, ok);
    capture_frame(1, FL, f0, f1, f2, w, bl, da, dn, rb);
    n_checks++;
    if (w != 1) begin n_fail++; $display("FAIL stuck_arm_wait: got %0d required 1", w); end
    n_checks++;
    if (f0 !== {1'b1, 1'b0, 8'h81, 1'b0}) begin
      n_fail++; $display("FAIL stuck_frame: got %b required %b", f0, {1'b1, 1'b0, 8'h81, 1'b0});
    end
    n_checks++;
    if (bl != 11 || da != 11 || dn != 1) begin
      n_fail++;
      $display("FAIL stuck_timing: got busy=%0d done_at=%0d pulses=%0d required 11 11 1", bl, da, dn);
    end
    tick_mode = 1;
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    done_pulses = 0;
    tick_mode   = 0;
    div_cnt     = 0;
    tick        = 1'b0;
    reset       = 1'b0;
    in_valid    = 1'b0;
    in_data     = 8'h00;

    test_reset();
    test_default_frame();
    test_parity_variants();
    test_back_to_back();
    test_reset_mid_frame();
    test_tick_gap();
    test_tick_stuck_high();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
